// File: rtl/control_fsm.sv
// control_fsm: multi-cycle Moore controller for a MIPS-style datapath.
// Inputs : clk, reset (async, active-low), OpCode[5:0] (instr bits 31:26),
//          mem_ready (memory access complete)
// Outputs: RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
//          NotBranch, jump, ALUOp[1:0], IRWrite, PCWrite, state[3:0],
//          illegal_op (sticky), instr_count[15:0] (retired instructions)
module control_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  OpCode,
    input  logic        mem_ready,
    output logic        RegDst,
    output logic        AluSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        NotBranch,
    output logic        jump,
    output logic [1:0]  ALUOp,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic [3:0]  state,
    output logic        illegal_op,
    output logic [15:0] instr_count
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        REXEC, RWB, BEQ, BNE, JUMP, IEXEC, IWB, ILLEGAL
    } state_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                           OP_J = 6'b000010, OP_ADDI = 6'b001000;

    state_t      cur, nxt;
    logic [15:0] count_q;
    logic        retire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur        <= IDLE;
            illegal_op <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            cur <= nxt;
            if (nxt == ILLEGAL)
                illegal_op <= 1'b1;
            if (retire)
                count_q <= count_q + 16'd1;
        end
    end

    // Memory states leave only when the access completes; ILLEGAL never retires.
    assign retire = (cur == MEMWB) || (cur == RWB) || (cur == IWB) || (cur == BEQ) ||
                    (cur == BNE) || (cur == JUMP) || (cur == MEMWR && mem_ready);

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    nxt = FETCH;
            FETCH:   nxt = mem_ready ? DECODE : FETCH;
            DECODE:  nxt = (OpCode == OP_R)                       ? REXEC  :
                           (OpCode == OP_LW || OpCode == OP_SW)   ? MEMADR :
                           (OpCode == OP_BEQ)                     ? BEQ    :
                           (OpCode == OP_BNE)                     ? BNE    :
                           (OpCode == OP_J)                       ? JUMP   :
                           (OpCode == OP_ADDI)                    ? IEXEC  : ILLEGAL;
            MEMADR:  nxt = (OpCode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
            MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
            REXEC:   nxt = RWB;
            IEXEC:   nxt = IWB;
            default: nxt = FETCH;
        endcase
    end

    always_comb begin
        RegDst    = 1'b0;
        AluSrc    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Branch    = 1'b0;
        NotBranch = 1'b0;
        jump      = 1'b0;
        ALUOp     = 2'b00;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        case (cur)
            FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            MEMADR, IEXEC: AluSrc = 1'b1;
            MEMRD: begin
                AluSrc  = 1'b1;
                MemRead = 1'b1;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                AluSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            REXEC: begin
                RegDst = 1'b1;
                ALUOp  = 2'b10;
            end
            RWB: begin
                RegDst   = 1'b1;
                ALUOp    = 2'b10;
                RegWrite = 1'b1;
            end
            IWB: begin
                AluSrc   = 1'b1;
                RegWrite = 1'b1;
            end
            BEQ: begin
                Branch = 1'b1;
                ALUOp  = 2'b01;
            end
            BNE: begin
                NotBranch = 1'b1;
                ALUOp     = 2'b01;
            end
            JUMP:    jump = 1'b1;
            default: ;
        endcase
    end

    assign state       = cur;
    assign instr_count = count_q;
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have ports clk (input, 1, rising-edge clock) and reset (input, 1, asynchronous, active-low: reset=0 resets).
REQ-002 SHALL have inputs OpCode [5:0] (instruction bits 31:26) and mem_ready [0:0] (memory access complete).
REQ-003 SHALL have 1-bit control outputs RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, NotBranch and jump, plus ALUOp [1:0], with datapath-defined meanings.
REQ-004 SHALL have 1-bit outputs IRWrite (latch instruction) and PCWrite (PC+4 update).
REQ-005 SHALL have outputs state [3:0] (current state), illegal_op [0:0] (sticky) and instr_count [15:0] (retired instructions).

Function
REQ-006 SHALL be a multi-cycle Moore controller; its only Mealy terms are IRWrite and PCWrite, which are gated by mem_ready.
REQ-007 State encoding SHALL be:
- IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6
- REXEC=7, RWB=8, BEQ=9, BNE=10, JUMP=11, IEXEC=12, IWB=13, ILLEGAL=14
REQ-008 Transitions: IDLE->FETCH unconditionally; FETCH holds while mem_ready=0 and goes FETCH->DECODE on mem_ready=1.
REQ-009 DECODE SHALL branch on OpCode:
- 000000 (R-type)->REXEC; 100011 (lw) or 101011 (sw)->MEMADR
- 000100->BEQ; 000101->BNE; 000010->JUMP; 001000 (addi)->IEXEC
- any other value->ILLEGAL
REQ-010 MEMADR->MEMRD for lw and MEMADR->MEMWR for sw, using the OpCode value held in MEMADR.
REQ-011 MEMRD and MEMWR SHALL hold while mem_ready=0; on mem_ready=1, MEMRD->MEMWB and MEMWR->FETCH.
REQ-012 Remaining transitions: MEMWB->FETCH; REXEC->RWB->FETCH; IEXEC->IWB->FETCH; BEQ, BNE and JUMP->FETCH; ILLEGAL->FETCH.
REQ-013 Outputs per state (anything not listed is 0):
- FETCH: MemRead=1; IRWrite=PCWrite=mem_ready
- MEMADR: AluSrc=1, ALUOp=00
- MEMRD: AluSrc=1, MemRead=1
- MEMWB: MemtoReg=1, RegWrite=1
- MEMWR: AluSrc=1, MemWrite=1
- REXEC: RegDst=1, ALUOp=10
- RWB: RegDst=1, ALUOp=10, RegWrite=1
- IEXEC: AluSrc=1, ALUOp=00
- IWB: AluSrc=1, RegWrite=1
- BEQ: Branch=1, ALUOp=01
- BNE: NotBranch=1, ALUOp=01
- JUMP: jump=1
REQ-014 Branch and NotBranch SHALL never be 1 together; MemRead and MemWrite SHALL never be 1 together.
REQ-015 illegal_op SHALL be set on entry to ILLEGAL and cleared only by reset.
REQ-016 instr_count SHALL increment by 1 on the clock edge leaving MEMWB, MEMWR (with mem_ready=1), RWB, IWB, BEQ, BNE or JUMP.
REQ-017 instr_count SHALL wrap from 16'hFFFF to 0, and SHALL NOT increment when leaving ILLEGAL.
REQ-018 ALUOp=11 SHALL never be driven.

Reset
REQ-019 While reset=0, state SHALL be IDLE and all outputs SHALL be 0, including illegal_op and instr_count; assertion takes effect immediately, independent of clk.
REQ-020 An asserted reset at any point mid-instruction SHALL abandon the instruction with no further RegWrite, MemWrite or PCWrite pulse.
REQ-021 After reset deasserts, the first clk edge SHALL move IDLE->FETCH.

Verification
REQ-022 lw, mem_ready=1 throughout -> states 0,1,2,3,4,5,1; exactly one RegWrite=1 cycle, in MEMWB, with MemtoReg=1; instr_count 0->1.
REQ-023 sw, mem_ready low for 3 cycles in MEMWR -> state stays 6 for 4 cycles with MemWrite=1; RegWrite never 1; count increments once.
REQ-024 R-type then beq then bne -> ALUOp 10/10, 01, 01; Branch=1 only in state 9, NotBranch=1 only in state 10; count=3.
REQ-025 OpCode=111111 in DECODE -> state 14, illegal_op=1 persisting through later instructions; count unchanged; next state 1.
REQ-026 reset=0 asynchronously during MEMRD -> outputs immediately 0, state 0; after release, FETCH next edge; IRWrite=0 while mem_ready=0.
REQ-027 Preload count to 16'hFFFE, run 2 jumps -> count FFFF then 0000; jump=1 only in state 11.
